mmio_ctrl: RTL and testbench

- Parametrised memory-mapped I/O controller between the CPU memory port and on-board RAM, switches and LEDs.
- Decodes `mem_cmd`/`mem_addr`, gates RAM writes and steers `read_data`.
- Adds functions the fixed top-level glue lacks: switch synchroniser, sticky switch rising-edge register (write-1-to-clear), loadable free-running timer, sticky bus-error flag for unmapped I/O accesses.

---
 rtl/mmio_ctrl.sv | 114 +++++++++++
 tb/tb_mmio_ctrl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_ctrl.sv
// Memory-mapped I/O controller: RAM/IO decode, LED register, synchronised switches
// with sticky rising-edge capture, loadable free-running timer and sticky bus-error flag.
module mmio_ctrl #(
  parameter int                DATA_W    = 16,
  parameter int                ADDR_W    = 9,
  parameter int                LED_W     = 10,
  parameter int                SW_W      = 10,
  parameter logic [ADDR_W-1:0] LED_ADDR  = 9'h100,
  parameter logic [ADDR_W-1:0] SW_ADDR   = 9'h140,
  parameter logic [ADDR_W-1:0] EDGE_ADDR = 9'h141,
  parameter logic [ADDR_W-1:0] TMR_ADDR  = 9'h142
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        mem_cmd,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] read_data,
  input  logic [DATA_W-1:0] ram_dout,
  output logic [ADDR_W-2:0] ram_addr,
  output logic              ram_write,
  input  logic [SW_W-1:0]   sw,
  output logic [LED_W-1:0]  ledr,
  output logic              bus_err
);

  typedef enum logic [1:0] {
    MNONE  = 2'b00,
    MREAD  = 2'b01,
    MWRITE = 2'b10,
    MRSVD  = 2'b11
  } mem_cmd_e;

  logic [LED_W-1:0]  r_ledr;
  logic [SW_W-1:0]   r_sw_meta;
  logic [SW_W-1:0]   r_sw_sync;
  logic [SW_W-1:0]   r_sw_prev;
  logic [SW_W-1:0]   r_edge_q;
  logic [DATA_W-1:0] r_tmr_q;
  logic              r_bus_err;

  logic              w_ram_sel;
  logic              w_io_sel;
  logic              w_rd;
  logic              w_wr;
  logic              w_hit_led;
  logic              w_hit_sw;
  logic              w_hit_edge;
  logic              w_hit_tmr;
  logic              w_mapped;
  logic              w_err_set;
  logic [SW_W-1:0]   w_edge_clr;
  logic [SW_W-1:0]   w_edge_rise;
  logic [DATA_W-1:0] w_read_data;

  assign w_ram_sel  = ~mem_addr[ADDR_W-1];
  assign w_io_sel   = mem_addr[ADDR_W-1];
  assign w_rd       = (mem_cmd == MREAD);
  assign w_wr       = (mem_cmd == MWRITE);

  assign w_hit_led  = w_io_sel & (mem_addr == LED_ADDR);
  assign w_hit_sw   = w_io_sel & (mem_addr == SW_ADDR);
  assign w_hit_edge = w_io_sel & (mem_addr == EDGE_ADDR);
  assign w_hit_tmr  = w_io_sel & (mem_addr == TMR_ADDR);
  assign w_mapped   = w_hit_led | w_hit_sw | w_hit_edge | w_hit_tmr;

  // The switch register is read-only, so a write to it counts as an illegal access.
  assign w_err_set  = w_io_sel & (w_rd | w_wr) & (~w_mapped | (w_wr & w_hit_sw));

  assign w_edge_clr  = (w_wr & w_hit_edge) ? write_data[SW_W-1:0] : '0;
  assign w_edge_rise = r_sw_sync & ~r_sw_prev;

  assign ram_write = w_wr & w_ram_sel;
  assign ram_addr  = mem_addr[ADDR_W-2:0];

  always_comb begin
    // NOTE: default assigned first so every path drives w_read_data and no latch is inferred.
    w_read_data = '0;
    if (w_rd) begin
      if (w_ram_sel)       w_read_data = ram_dout;
      else if (w_hit_sw)   w_read_data = DATA_W'(r_sw_sync);
      else if (w_hit_edge) w_read_data = DATA_W'(r_edge_q);
      else if (w_hit_tmr)  w_read_data = r_tmr_q;
      else if (w_hit_led)  w_read_data = DATA_W'(r_ledr);
    end
  end

  assign read_data = w_read_data;
  assign ledr      = r_ledr;
  assign bus_err   = r_bus_err;

  // NOTE: non-blocking assignments so every flop samples the pre-edge values of the others.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ledr    <= '0;
      r_sw_meta <= '0;
      r_sw_sync <= '0;
      r_sw_prev <= '0;
      r_edge_q  <= '0;
      r_tmr_q   <= '0;
      r_bus_err <= 1'b0;
    end else begin
      r_sw_meta <= sw;
      r_sw_sync <= r_sw_meta;
      r_sw_prev <= r_sw_sync;
      // Set term is OR-ed last so a new edge survives a same-cycle clear.
      r_edge_q  <= (r_edge_q & ~w_edge_clr) | w_edge_rise;
      r_tmr_q   <= (w_wr & w_hit_tmr) ? write_data : r_tmr_q + DATA_W'(1);
      if (w_wr & w_hit_led) r_ledr <= write_data[LED_W-1:0];
      if (w_err_set)        r_bus_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mmio_ctrl.sv
// Self-checking bench for mmio_ctrl: directed vector table, hand-written corner
// sequences and randomized traffic compared against a behavioural model.
module tb_mmio_ctrl;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 9;
  localparam int LED_W  = 10;
  localparam int SW_W   = 10;

  localparam logic [1:0] C_NONE  = 2'b00;
  localparam logic [1:0] C_READ  = 2'b01;
  localparam logic [1:0] C_WRITE = 2'b10;
  localparam logic [1:0] C_RSVD  = 2'b11;

  logic              clk = 1'b0;
  logic              reset;
  logic [1:0]        mem_cmd;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] write_data;
  logic [DATA_W-1:0] read_data;
  logic [DATA_W-1:0] ram_dout;
  logic [ADDR_W-2:0] ram_addr;
  logic              ram_write;
  logic [SW_W-1:0]   sw;
  logic [LED_W-1:0]  ledr;
  logic              bus_err;

  mmio_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .mem_cmd    (mem_cmd),
    .mem_addr   (mem_addr),
    .write_data (write_data),
    .read_data  (read_data),
    .ram_dout   (ram_dout),
    .ram_addr   (ram_addr),
    .ram_write  (ram_write),
    .sw         (sw),
    .ledr       (ledr),
    .bus_err    (bus_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: switches are seen as the sample taken two edges ago,
  // and the previous-synchronised value as the sample taken three edges ago.
  logic [LED_W-1:0]  m_led;
  logic [DATA_W-1:0] m_tmr;
  logic [SW_W-1:0]   m_edge;
  logic              m_err;
  logic [SW_W-1:0]   sw_hist [3];
  logic [SW_W-1:0]   cur_sw;

  logic [DATA_W-1:0] last_rd;
  logic              last_ramwr;
  logic              last_err;

  task automatic model_reset();
    m_led  = '0;
    m_tmr  = '0;
    m_edge = '0;
    m_err  = 1'b0;
    for (int i = 0; i < 3; i++) sw_hist[i] = '0;
  endtask

  function automatic logic [DATA_W-1:0] model_read(input logic [1:0] cmd,
                                                   input logic [ADDR_W-1:0] addr,
                                                   input logic [DATA_W-1:0] rdout);
    if (cmd != C_READ) return '0;
    if (!addr[ADDR_W-1]) return rdout;
    case (addr)
      9'h100:  return DATA_W'(m_led);
      9'h140:  return DATA_W'(sw_hist[1]);
      9'h141:  return DATA_W'(m_edge);
      9'h142:  return m_tmr;
      default: return '0;
    endcase
  endfunction

  task automatic model_edge(input logic [1:0] cmd, input logic [ADDR_W-1:0] addr,
                            input logic [DATA_W-1:0] wdata, input logic [SW_W-1:0] swv);
    bit              rd;
    bit              wr;
    bit              mapped;
    logic [SW_W-1:0] rise;
    logic [SW_W-1:0] clr;
    rd     = (cmd == C_READ);
    wr     = (cmd == C_WRITE);
    mapped = addr inside {9'h100, 9'h140, 9'h141, 9'h142};
    rise   = sw_hist[1] & ~sw_hist[2];
    clr    = (wr && addr == 9'h141) ? wdata[SW_W-1:0] : '0;
    if (addr[ADDR_W-1] && (rd || wr) && (!mapped || (wr && addr == 9'h140))) m_err = 1'b1;
    if (wr && addr == 9'h100) m_led = wdata[LED_W-1:0];
    m_tmr  = (wr && addr == 9'h142) ? wdata : DATA_W'((32'(m_tmr) + 1) % 65536);
    m_edge = (m_edge & ~clr) | rise;
    sw_hist[2] = sw_hist[1];
    sw_hist[1] = sw_hist[0];
    sw_hist[0] = swv;
  endtask

  // Entered and left at posedge+1; outputs are checked at the falling edge.
  task automatic step(input logic [1:0] cmd, input logic [ADDR_W-1:0] addr,
                      input logic [DATA_W-1:0] wdata = '0, input logic [DATA_W-1:0] rdout = '0);
    mem_cmd    = cmd;
    mem_addr   = addr;
    write_data = wdata;
    ram_dout   = rdout;
    sw         = cur_sw;
    @(negedge clk);
    last_rd    = read_data;
    last_ramwr = ram_write;
    last_err   = bus_err;
    check("read_data", read_data, model_read(cmd, addr, rdout));
    check("ram_write", ram_write, (cmd == C_WRITE) && !addr[ADDR_W-1]);
    check("ram_addr",  ram_addr,  addr[ADDR_W-2:0]);
    check("ledr",      ledr,      m_led);
    check("bus_err",   bus_err,   m_err);
    @(posedge clk);
    if (reset) model_reset();
    else       model_edge(cmd, addr, wdata, cur_sw);
    #1;
  endtask

  task automatic do_reset();
    mem_cmd = C_NONE;
    reset   = 1'b1;
    #2;
    model_reset();
    @(posedge clk);
    #1;
    reset   = 1'b0;
  endtask

  typedef struct {
    logic [1:0]        cmd;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdout;
    logic [DATA_W-1:0] exp_rd;
    logic              exp_ramwr;
    logic              exp_err;
  } vec_t;

  vec_t vecs [13];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{C_WRITE, 9'h100, 16'h02A5, 16'h0000, 16'h0000, 1'b0, 1'b0};
    vecs[1]  = '{C_READ,  9'h100, 16'h0000, 16'h0000, 16'h02A5, 1'b0, 1'b0};
    vecs[2]  = '{C_WRITE, 9'h100, 16'hFC00, 16'h0000, 16'h0000, 1'b0, 1'b0};
    vecs[3]  = '{C_READ,  9'h100, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0};
    vecs[4]  = '{C_WRITE, 9'h0A3, 16'h1234, 16'h0000, 16'h0000, 1'b1, 1'b0};
    vecs[5]  = '{C_READ,  9'h0A3, 16'h0000, 16'hBEEF, 16'hBEEF, 1'b0, 1'b0};
    vecs[6]  = '{C_RSVD,  9'h150, 16'hFFFF, 16'h0000, 16'h0000, 1'b0, 1'b0};
    vecs[7]  = '{C_NONE,  9'h150, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0};
    vecs[8]  = '{C_READ,  9'h150, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0};
    vecs[9]  = '{C_NONE,  9'h000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b1};
    vecs[10] = '{C_WRITE, 9'h140, 16'h03FF, 16'h0000, 16'h0000, 1'b0, 1'b1};
    vecs[11] = '{C_READ,  9'h140, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b1};
    vecs[12] = '{C_WRITE, 9'h1FF, 16'h5555, 16'h0000, 16'h0000, 1'b0, 1'b1};

    reset = 1'b1; mem_cmd = C_NONE; mem_addr = '0; write_data = '0; ram_dout = '0;
    cur_sw = '0; sw = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state
    step(C_READ, 9'h142); check("rst_tmr",  last_rd, 16'h0000);
    step(C_READ, 9'h100); check("rst_led",  last_rd, 16'h0000);
    step(C_READ, 9'h141); check("rst_edge", last_rd, 16'h0000);
    check("rst_err", last_err, 1'b0);

    // Asynchronous reset mid-count
    step(C_WRITE, 9'h100, 16'h03FF);
    step(C_WRITE, 9'h142, 16'h0122);
    step(C_NONE,  9'h000);
    mem_cmd = C_READ; mem_addr = 9'h142;
    #1 check("t1_tmr_pre", read_data, 16'h0123);
    check("t1_led_pre", ledr, 10'h3FF);
    #1 reset = 1'b1;
    #1 check("t1_tmr_rst", read_data, 16'h0000);
    check("t1_led_rst", ledr, 10'h000);
    check("t1_err_rst", bus_err, 1'b0);
    model_reset();
    @(posedge clk);
    #1 reset = 1'b0;

    // Directed vector table: LED, RAM pass-through, reserved command, bus error
    for (int i = 0; i < 13; i++) begin
      step(vecs[i].cmd, vecs[i].addr, vecs[i].wdata, vecs[i].rdout);
      check($sformatf("tbl%0d_rd", i),    last_rd,    vecs[i].exp_rd);
      check($sformatf("tbl%0d_ramwr", i), last_ramwr, vecs[i].exp_ramwr);
      check($sformatf("tbl%0d_err", i),   last_err,   vecs[i].exp_err);
    end
    check("tbl_err_sticky", bus_err, 1'b1);

    // Switch synchroniser latency and sticky rising-edge capture
    do_reset();
    cur_sw = 10'h005;
    step(C_READ, 9'h140); check("t3_sync0", last_rd, 16'h0000);
    step(C_READ, 9'h140); check("t3_sync1", last_rd, 16'h0000);
    step(C_READ, 9'h140); check("t3_sync2", last_rd, 16'h0005);
    step(C_READ, 9'h141); check("t3_edge",  last_rd, 16'h0005);
    cur_sw = 10'h000;
    for (int i = 0; i < 3; i++) begin
      step(C_READ, 9'h141); check("t3_edge_hold", last_rd, 16'h0005);
    end

    // Clear colliding with a new bit-0 edge, then a plain clear
    cur_sw = 10'h001;
    step(C_NONE, 9'h000);
    step(C_NONE, 9'h000);
    step(C_WRITE, 9'h141, 16'h0001);
    step(C_READ,  9'h141); check("t4_set_wins", last_rd, 16'h0005);
    step(C_WRITE, 9'h141, 16'h0001);
    step(C_READ,  9'h141); check("t4_clear",    last_rd, 16'h0004);
    check("t4_no_err", bus_err, 1'b0);

    // Timer wrap
    step(C_WRITE, 9'h142, 16'hFFFE);
    step(C_NONE,  9'h000);
    step(C_READ,  9'h142); check("t5_ffff", last_rd, 16'hFFFF);
    step(C_READ,  9'h142); check("t5_wrap", last_rd, 16'h0000);

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 400; i++) begin
      logic [1:0]        cmd;
      logic [ADDR_W-1:0] addr;
      int                sel;
      cmd = 2'($urandom_range(0, 3));
      sel = $urandom_range(0, 5);
      case (sel)
        0, 1:    addr = {1'b0, 8'($urandom)};
        2:       addr = 9'h100;
        3:       addr = 9'h140 + 9'($urandom_range(0, 2));
        4:       addr = 9'h141;
        default: addr = {1'b1, 8'($urandom)};
      endcase
      if ($urandom_range(0, 3) == 0) cur_sw = SW_W'($urandom);
      step(cmd, addr, DATA_W'($urandom), DATA_W'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
